ex_div: RTL and testbench
=========================

// Module: ex_div
// PURPOSE
//  Multi-cycle RV32M divider (DIV/DIVU/REM/REMU) in the execute stage, fed by the
//  id_ex pipeline register outputs (operands, destination register address).
//  Computes one quotient bit per cycle with a radix-2 restoring algorithm.
//  Raises hold_req so the hold controller freezes IF/ID/ID_EX while it is busy.
//  Returns the result, destination address and write-enable to the ex write-back mux.
// PARAMETERS
//  XLEN  32  operand/result width; the iteration count equals XLEN
// PORTS
//  clk        in   1     clock
//  rst        in   1     reset, synchronous, active-high
//  start      in   1     ex decoded a DIV* or REM* op; operands valid this cycle
//  op         in   2     00 DIV, 01 DIVU, 10 REM, 11 REMU
//  dividend   in   XLEN  rs1 value (ex_reg1)
//  divisor    in   XLEN  rs2 value (ex_reg2)
//  waddr_i    in   5     destination register (ex_reg_waddr)
//  kill       in   1     flush from a taken jump or branch; aborts the operation
//  busy       out  1     state != IDLE
//  hold_req   out  1     stall request to the hold controller
//  done       out  1     one-cycle pulse; result valid
//  result     out  XLEN  quotient or remainder
//  waddr_o    out  5     latched waddr_i, valid with done
//  we_o       out  1     register write-enable; equals done
// BEHAVIOUR
//  Reset: state=IDLE; busy, hold_req, done, we_o=0; result=0; waddr_o=0; count=0.
//  FSM states IDLE -> CALC -> FINISH -> IDLE.
//   IDLE: start & !kill latches op, waddr_i, and sign flags (signed ops only:
//    neg_q = dividend[31]^divisor[31], neg_r = dividend[31]), plus absolute values
//    (for signed ops) of dividend and divisor. rem clears to 0 and count to 0. Next state CALC.
//   CALC: each cycle rem' = {rem[XLEN-2:0], dvd[XLEN-1]} and dvd shifts left by 1.
//    If rem' >= dvs then rem = rem' - dvs and the quotient bit is 1; otherwise rem = rem'
//    and the bit is 0. Quotient bits shift into dvd[0]. Use an XLEN+1-bit compare/subtract.
//    After XLEN cycles (count == XLEN-1) the next state is FINISH.
//   FINISH: apply sign correction, drive result, and pulse done/we_o for 1 cycle.
//    Next state IDLE.
//  Latency: done is high exactly XLEN+1 = 33 cycles after the accepting edge.
//   A new start is accepted in the cycle after done, so back-to-back ops are possible.
//  Sign correction: quotient is negated if neg_q and divisor != 0; remainder is
//   negated if neg_r.
//  Divide by zero: quotient = all ones; remainder = dividend (per the RISC-V spec).
//  Overflow: DIV 0x80000000 / 0xFFFFFFFF gives 0x80000000, and REM gives 0.
//   This falls out of the unsigned datapath and needs no special case.
//  hold_req = (start & !kill & state==IDLE) | state==CALC.
//   It deasserts in the FINISH cycle so the pipeline advances while done is high.
//  start while busy: ignored. start & kill in the same cycle: kill wins.
//  kill in CALC or FINISH: next state is IDLE, with no done and no we_o.
//   result and waddr_o hold their previous values.
//  rst mid-operation: same as kill; all outputs return to their reset values.
//  result and waddr_o hold their values after done until the next FINISH.
// CONFIGURATION
//  DIV_ZERO_FAST_EN defined: when the divisor is 0 at accept, go IDLE -> FINISH directly.
//   done then arrives 1 cycle after accept and hold_req is high only in the accept cycle.
//   The divide-by-zero results are the same as above.
//  DIV_ZERO_FAST_EN undefined: divide by zero takes the full 33-cycle path.
// TESTING
//  DIVU 100/7, waddr_i=5 -> done at +33; result 14; waddr_o 5; we_o 1 for one cycle.
//  DIV -7/2 = 0xFFFFFFF9/2 -> result 0xFFFFFFFD (-3). REM -7/2 -> 0xFFFFFFFF (-1).
//  DIV 0x80000000/0xFFFFFFFF -> 0x80000000. REM of the same operands -> 0.
//  DIV 123/0 -> 0xFFFFFFFF; REMU 123/0 -> 123. Latency is 33 (1 with DIV_ZERO_FAST_EN).
//  kill at cycle 10 of CALC -> busy 0 next cycle; done never pulses.
//   The next start then completes normally.
//  start held high through busy -> exactly one done. Assert rst in CALC -> all outputs 0.

Source files
------------

// File: rtl/ex_div.sv
// ex_div: multi-cycle RV32M divider (DIV/DIVU/REM/REMU) for the execute stage.
// Latency: done pulses XLEN+1 cycles after the accepting edge, or 1 cycle after it when
//   DIV_ZERO_FAST_EN is defined and the divisor is zero.
// Backpressure: start is ignored while busy; hold_req freezes IF/ID/ID_EX until the FINISH cycle.
//
// Optional feature macro: DIV_ZERO_FAST_EN (divide by zero skips the iteration loop).
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start, op         request a DIV* / REM* op (00 DIV, 01 DIVU, 10 REM, 11 REMU)
//   dividend, divisor rs1 / rs2 operand values, sampled with start
//   waddr_i           destination register, returned on waddr_o with done
//   kill              flush; aborts an accept or an operation in flight
//   busy, hold_req    status and stall request to the hold controller
//   done, we_o        one-cycle result-valid / register write-enable pulse
//   result, waddr_o   quotient or remainder and its destination; hold until next FINISH
module ex_div #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic [4:0]      waddr_i,
  input  logic            kill,
  output logic            busy,
  output logic            hold_req,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      waddr_o,
  output logic            we_o
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t          state_q;
  logic [XLEN-1:0] dvd_q;      // dividend magnitude, becomes the quotient as bits shift in
  logic [XLEN-1:0] dvs_q;      // divisor magnitude
  logic [XLEN-1:0] rem_q;
  logic [CW-1:0]   count_q;
  logic            op_rem_q;
  logic            neg_quo_q;
  logic            neg_rem_q;
  logic            dvs_zero_q;
  logic [4:0]      waddr_q;
  logic            done_q;
  logic [XLEN-1:0] result_q;
  logic [4:0]      waddr_o_q;

  logic            accept;
  logic            signed_op;
  logic [XLEN-1:0] dvd_abs;
  logic [XLEN-1:0] dvs_abs;
  logic [XLEN:0]   rem_sh;
  logic [XLEN:0]   diff;
  logic [XLEN-1:0] quo_fin;
  logic [XLEN-1:0] rem_fin;

  assign accept    = start & ~kill & (state_q == IDLE);
  assign signed_op = ~op[0];
  assign dvd_abs   = (signed_op & dividend[XLEN-1]) ? (~dividend + 1'b1) : dividend;
  assign dvs_abs   = (signed_op & divisor[XLEN-1])  ? (~divisor + 1'b1)  : divisor;

  // The partial remainder is always below the divisor, so after the shift it can need one
  // extra bit; the borrow out of the XLEN+1-bit subtract selects the quotient bit.
  assign rem_sh = {rem_q, dvd_q[XLEN-1]};
  assign diff   = rem_sh - {1'b0, dvs_q};

  // With a zero divisor the loop yields all-ones / |dividend|; leaving the quotient
  // un-negated and restoring the remainder sign gives the RISC-V divide-by-zero results.
  assign quo_fin = (neg_quo_q & ~dvs_zero_q) ? (~dvd_q + 1'b1) : dvd_q;
  assign rem_fin = neg_rem_q ? (~rem_q + 1'b1) : rem_q;

  assign busy     = (state_q != IDLE);
  assign hold_req = accept | (state_q == CALC);
  assign done     = done_q;
  assign we_o     = done_q;
  assign result   = result_q;
  assign waddr_o  = waddr_o_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      dvd_q      <= '0;
      dvs_q      <= '0;
      rem_q      <= '0;
      count_q    <= '0;
      op_rem_q   <= 1'b0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      dvs_zero_q <= 1'b0;
      waddr_q    <= '0;
      done_q     <= 1'b0;
      result_q   <= '0;
      waddr_o_q  <= '0;
    end else begin
      done_q <= 1'b0;
      if (kill) begin
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (accept) begin
              op_rem_q   <= op[1];
              neg_quo_q  <= signed_op & (dividend[XLEN-1] ^ divisor[XLEN-1]);
              neg_rem_q  <= signed_op & dividend[XLEN-1];
              dvs_zero_q <= (divisor == '0);
              waddr_q    <= waddr_i;
              dvd_q      <= dvd_abs;
              dvs_q      <= dvs_abs;
              rem_q      <= '0;
              count_q    <= '0;
              state_q    <= CALC;
`ifdef DIV_ZERO_FAST_EN
              if (divisor == '0) begin
                dvd_q   <= '1;
                rem_q   <= dvd_abs;
                state_q <= FINISH;
              end
`endif
            end
          end
          CALC: begin
            if (!diff[XLEN]) begin
              rem_q <= diff[XLEN-1:0];
              dvd_q <= {dvd_q[XLEN-2:0], 1'b1};
            end else begin
              rem_q <= rem_sh[XLEN-1:0];
              dvd_q <= {dvd_q[XLEN-2:0], 1'b0};
            end
            count_q <= count_q + 1'b1;
            if (count_q == CW'(XLEN - 1)) begin
              state_q <= FINISH;
            end
          end
          FINISH: begin
            done_q    <= 1'b1;
            result_q  <= op_rem_q ? rem_fin : quo_fin;
            waddr_o_q <= waddr_q;
            state_q   <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ex_div.sv
// tb_ex_div: randomized and directed stimulus for ex_div; expected results go into a
// queue when an op is issued and a monitor pops and compares on every done pulse.
module tb_ex_div;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        kill = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic [4:0]  waddr_i = '0;
  logic        busy, hold_req, done, we_o;
  logic [31:0] result;
  logic [4:0]  waddr_o;

  ex_div #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .dividend(dividend),
    .divisor(divisor), .waddr_i(waddr_i), .kill(kill), .busy(busy),
    .hold_req(hold_req), .done(done), .result(result), .waddr_o(waddr_o), .we_o(we_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  wa;
    int          due;
  } exp_t;

  exp_t        sb_q[$];
  int          tests = 0;
  int          fails = 0;
  int          done_cnt = 0;
  logic        done_prev = 1'b0;
  logic [31:0] last_res = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Architectural RV32M results, including the divide-by-zero and overflow cases.
  function automatic logic [31:0] ref_model(input logic [1:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
    int  sa, sb;
    logic ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (o)
      2'd0:    if (b == 0) return 32'hFFFF_FFFF; else if (ovf) return a; else return 32'(sa / sb);
      2'd1:    if (b == 0) return 32'hFFFF_FFFF; else return a / b;
      2'd2:    if (b == 0) return a; else if (ovf) return 32'h0; else return 32'(sa % sb);
      default: if (b == 0) return a; else return a % b;
    endcase
  endfunction

  function automatic int latency(input logic [31:0] b);
`ifdef DIV_ZERO_FAST_EN
    if (b == 0) return 1;
`endif
    return 33;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      exp_t e;
      done_cnt++;
      if (done_prev) begin
        tests++; fails++;
        $display("FAIL done_width: done high on consecutive cycles");
      end
      if (sb_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_done: result %h waddr %0d, expected no done", result, waddr_o);
      end else begin
        e = sb_q.pop_front();
        chk("result", result, e.res);
        chk("waddr_o", 32'(waddr_o), 32'(e.wa));
        chk("we_o", 32'(we_o), 32'd1);
        chk("latency", cyc, e.due);
      end
    end
    done_prev = done;
  end

  task automatic wait_idle();
    int g = 0;
    @(negedge clk);
    while (busy && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (busy) begin
      tests++; fails++;
      $display("FAIL idle_timeout: busy still 1, expected 0");
    end
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] w, input bit expect_done);
    exp_t e;
    wait_idle();
    start = 1'b1; op = o; dividend = a; divisor = b; waddr_i = w;
    if (expect_done) begin
      e.res = ref_model(o, a, b);
      e.wa  = w;
      e.due = cyc + 1 + latency(b);
      sb_q.push_back(e);
      last_res = e.res;
    end
    #1 chk("hold_accept", 32'(hold_req), 32'd1);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while (sb_q.size() != 0 && g < 200) begin
      @(negedge clk);
      g++;
    end
    chk("drain", sb_q.size(), 0);
  endtask

  initial begin
    int d0;
    logic [31:0] a, b;
    logic [1:0]  o;

    repeat (4) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_hold", 32'(hold_req), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_result", result, 0);
    chk("rst_waddr", 32'(waddr_o), 0);
    rst = 1'b0;

    // DIVU 100/7 with pipeline-stall timing checks along the way.
    issue(2'd1, 32'd100, 32'd7, 5'd5, 1'b1);
    repeat (15) @(negedge clk);
    chk("calc_busy", 32'(busy), 1);
    chk("calc_hold", 32'(hold_req), 1);
    repeat (17) @(negedge clk);
    chk("finish_hold", 32'(hold_req), 0);
    chk("finish_busy", 32'(busy), 1);
    chk("finish_done", 32'(done), 0);

    // Back-to-back directed corner cases.
    issue(2'd0, 32'hFFFF_FFF9, 32'd2, 5'd1, 1'b1);
    issue(2'd2, 32'hFFFF_FFF9, 32'd2, 5'd2, 1'b1);
    issue(2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd3, 1'b1);
    issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4, 1'b1);
    issue(2'd0, 32'd123, 32'd0, 5'd6, 1'b1);
    issue(2'd3, 32'd123, 32'd0, 5'd7, 1'b1);
    issue(2'd2, 32'hFFFF_FF85, 32'd0, 5'd8, 1'b1);
    drain();

    // Kill in the 10th CALC cycle: no done, outputs hold, next op is normal.
    issue(2'd1, 32'd5000, 32'd3, 5'd9, 1'b0);
    repeat (9) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    chk("kill_busy", 32'(busy), 0);
    chk("kill_result_hold", result, last_res);
    repeat (40) @(negedge clk);
    issue(2'd3, 32'd5000, 32'd3, 5'd10, 1'b1);
    drain();

    // start and kill together: kill wins.
    wait_idle();
    start = 1'b1; kill = 1'b1; op = 2'd1; dividend = 32'd9; divisor = 32'd2;
    #1 chk("startkill_hold", 32'(hold_req), 0);
    @(negedge clk);
    start = 1'b0; kill = 1'b0;
    chk("startkill_busy", 32'(busy), 0);

    // start held through busy: exactly one done.
    wait_idle();
    d0 = done_cnt;
    begin
      exp_t e;
      start = 1'b1; op = 2'd1; dividend = 32'd77; divisor = 32'd10; waddr_i = 5'd11;
      e.res = 32'd7; e.wa = 5'd11; e.due = cyc + 34;
      sb_q.push_back(e);
      last_res = e.res;
    end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) break;
    end
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("held_start_dones", done_cnt - d0, 1);
    chk("held_start_idle", 32'(busy), 0);

    // Randomized ops from a few operand classes.
    for (int n = 0; n < 40; n++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 4))
        0: ;
        1: b = ($urandom_range(0, 1) != 0) ? -32'($urandom_range(1, 15)) : 32'($urandom_range(1, 15));
        2: b = 32'd0;
        3: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        default: a = 32'($urandom_range(0, 1000));
      endcase
      issue(o, a, b, 5'($urandom), 1'b1);
    end
    drain();

    // Reset during CALC returns every output to its reset value.
    issue(2'd0, 32'd1000, 32'd7, 5'd12, 1'b0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_hold", 32'(hold_req), 0);
    chk("midrst_result", result, 0);
    chk("midrst_waddr", 32'(waddr_o), 0);
    rst = 1'b0;
    issue(2'd0, 32'd1000, 32'd7, 5'd13, 1'b1);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
